mem_sweep_ctrl: RTL
===================

Name: mem_sweep_ctrl

Overview:
- Sequencing controller for a simple-dual-port block RAM. The default geometry is 256 x 128, with 1-cycle registered read data.
- On command it performs one of three whole-array sweeps:
  - fill the array with a seeded pattern;
  - read back every word and compute a signature;
  - fill, then verify every word against the pattern.
- It sits between configuration/test logic and the memory's raddr/waddr/din/dout ports. It is used to reinitialise and check memory contents in-system.

Parameters:
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words swept.
- DATA_W, 128, word width; must be an integer multiple of ADDR_W.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- mode  input  2  00 = readback/signature, 01 = fill, 10 = fill+verify, 11 = treated as 00.
- seed  input  DATA_W  pattern seed; captured at start acceptance.
- abort  input  1  synchronous cancel of the current sweep.
- mem_raddr  output  ADDR_W  memory read address.
- mem_waddr  output  ADDR_W  memory write address.
- mem_din  output  DATA_W  memory write data.
- mem_we  output  1  memory write enable; the memory writes only when it is 1.
- mem_dout  input  DATA_W  memory read data, valid 1 cycle after mem_raddr.
- busy  output  1  sweep in progress.
- done  output  1  1-cycle pulse on sweep completion.
- signature  output  DATA_W  readback signature (modes 00 and 10).
- err_count  output  ADDR_W+1  number of mismatching words (mode 10).
- first_err_addr  output  ADDR_W  address of the first mismatch.
- err_flag  output  1  err_count != 0.

Behaviour:
- Reset (async assert, sync release): state = IDLE. All outputs are 0, including mem_we, mem_raddr, mem_waddr, mem_din, busy, done, signature, err_count, first_err_addr and err_flag. A reset asserted mid-sweep takes effect immediately; no done pulse is produced.
- Pattern: pat(a) = seed_q XOR {DATA_W/ADDR_W copies of a}, where seed_q is the seed captured at start acceptance.
- States:
  - IDLE: waits for start.
  - FILL, READ, DRAIN, FIN: one cycle each per step, as below.
- Start acceptance (cycle T, state IDLE, start = 1):
  - capture seed and mode;
  - clear signature, err_count, first_err_addr and err_flag;
  - busy = 1 from T+1.
  - start in any state other than IDLE is ignored.
- FILL (DEPTH cycles):
  - mem_we = 1, mem_waddr = a, mem_din = pat(a), for a = 0..DEPTH-1 on consecutive cycles.
  - Mode 01 goes to FIN after a = DEPTH-1. Mode 10 goes to READ.
- READ (DEPTH cycles):
  - mem_we = 0; mem_raddr = a for a = 0..DEPTH-1 on consecutive cycles.
  - A 1-bit valid pipe and an address pipe track the returning data.
- DRAIN (1 cycle): consumes the data for the last address. Then go to FIN.
- Data processing: on each cycle with a valid returned word d for address a:
  - signature <= rotl(signature, 1) XOR d;
  - mode 10 only: if d != pat(a), then err_count++ and err_flag <= 1. If this is the first mismatch, first_err_addr <= a.
- err_count range: 0..DEPTH, so it cannot overflow.
- FIN (1 cycle): done = 1, busy = 0. Then go to IDLE.
- Busy windows relative to start cycle T:
  - Mode 00: busy T+1..T+257, done at T+258.
  - Mode 01: busy T+1..T+256, done at T+257.
  - Mode 10: busy T+1..T+513, done at T+514.
- Result outputs are held from FIN until the next accepted start.
- mem_we is 0 in every state except FILL. mem_raddr and mem_waddr hold their last value when idle.
- Abort (any non-IDLE state except FIN):
  - next state is IDLE; mem_we = 0 and busy = 0 the next cycle; no done pulse;
  - results are left partial and must not be trusted.
  - If abort and start occur together in IDLE, start wins (abort is a no-op in IDLE).
- Address counter wraps only via the state transition; no address beyond DEPTH-1 is driven.

Test Plan:
- Reset, then mode 01 with seed = 0, then mode 00 on the RAM model. Required response:
  - word a == {16{a}} for every a;
  - signature equals the bench reference model;
  - done at T+257 (mode 01) and T+258 (mode 00), each a single pulse.
- Mode 10 with seed = 128'hA5A5...A5 on a good RAM. Required response:
  - err_count = 0, err_flag = 0, first_err_addr = 0;
  - done exactly at T+514.
- Mode 10 with the bench flipping bit 0 of mem_dout for addr 0x37 and 0xC0. Required response:
  - err_count = 2, first_err_addr = 0x37, err_flag = 1.
- Abort at T+100 during mode 10 FILL. Required response:
  - busy = 0 and mem_we = 0 at T+101;
  - no done pulse;
  - a new start is then accepted normally.
- Start pulsed at T+50 of a running mode 00 sweep. Required response: ignored; the timing and signature of the running sweep are unchanged.
- Async reset asserted mid-READ between clock edges. Required response:
  - all outputs go to 0 before the next edge;
  - state returns to IDLE and no done pulse follows.

Source files
------------

// File: rtl/mem_sweep_ctrl.sv
// Whole-array sweep sequencer for a simple-dual-port RAM with 1-cycle registered read data.
// Fills with a seeded pattern, reads back into a rotating signature, or fills then verifies.
module mem_sweep_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] signature,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              err_flag
);

    localparam int unsigned Reps = DATA_W / ADDR_W;
    localparam logic [ADDR_W-1:0] LastAddr = '1;
    localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StRead,
        StDrain,
        StFin
    } state_e;

    state_e              state_q, state_d;
    logic                verify_q, verify_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic                rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]   sig_q, sig_d;
    logic [ADDR_W:0]     err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_q, first_d;
    logic                err_flag_q, err_flag_d;
    logic                accept;

    function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] s,
                                              input logic [ADDR_W-1:0] a);
        return s ^ {Reps{a}};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            verify_q   <= 1'b0;
            seed_q     <= '0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            sig_q      <= '0;
            err_cnt_q  <= '0;
            first_q    <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            verify_q   <= verify_d;
            seed_q     <= seed_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            sig_q      <= sig_d;
            err_cnt_q  <= err_cnt_d;
            first_q    <= first_d;
            err_flag_q <= err_flag_d;
        end
    end

    // Sequencing: the address counters stop at the last address, so the wrap back
    // to zero only ever happens through a state transition.
    always_comb begin
        state_d  = state_q;
        verify_d = verify_q;
        seed_d   = seed_q;
        waddr_d  = waddr_q;
        raddr_d  = raddr_q;
        accept   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept   = 1'b1;
                    seed_d   = seed;
                    verify_d = (mode == 2'b10);
                    if (mode == 2'b01 || mode == 2'b10) begin
                        state_d = StFill;
                        waddr_d = '0;
                    end else begin
                        state_d = StRead;
                        raddr_d = '0;
                    end
                end
            end
            StFill: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (waddr_q == LastAddr) begin
                    if (verify_q) begin
                        state_d = StRead;
                        raddr_d = '0;
                    end else begin
                        state_d = StFin;
                    end
                end else begin
                    waddr_d = waddr_q + AddrOne;
                end
            end
            StRead: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (raddr_q == LastAddr) begin
                    state_d = StDrain;
                end else begin
                    raddr_d = raddr_q + AddrOne;
                end
            end
            StDrain: begin
                state_d = abort ? StIdle : StFin;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Read return tracking: data for the address issued this cycle arrives next cycle.
    always_comb begin
        rd_valid_d = (state_q == StRead) && !abort;
        rd_addr_d  = raddr_q;
    end

    always_comb begin
        sig_d      = sig_q;
        err_cnt_d  = err_cnt_q;
        first_d    = first_q;
        err_flag_d = err_flag_q;
        if (accept) begin
            sig_d      = '0;
            err_cnt_d  = '0;
            first_d    = '0;
            err_flag_d = 1'b0;
        end else if (rd_valid_q) begin
            sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ mem_dout;
            if (verify_q && (mem_dout != pat(seed_q, rd_addr_q))) begin
                err_cnt_d  = err_cnt_q + CntOne;
                err_flag_d = 1'b1;
                if (!err_flag_q) begin
                    first_d = rd_addr_q;
                end
            end
        end
    end

    always_comb begin
        mem_we         = (state_q == StFill);
        mem_waddr      = waddr_q;
        mem_raddr      = raddr_q;
        mem_din        = mem_we ? pat(seed_q, waddr_q) : '0;
        busy           = (state_q == StFill) || (state_q == StRead) || (state_q == StDrain);
        done           = (state_q == StFin);
        signature      = sig_q;
        err_count      = err_cnt_q;
        first_err_addr = first_q;
        err_flag       = err_flag_q;
    end

endmodule
